ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline: ID/EX pipeline register, forwarding operand muxes, ALU, and EX/MEM pipeline register.
- Consumes FORWARD_A/FORWARD_B from the forwarding unit.
- Supplies that unit's ARS1/ARS2 (from ID/EX) and ARD_EX_MEM/REGWRITE_EX_MEM (from EX/MEM).

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- STALL  in  1  load-use stall from hazard unit; inserts bubble into ID/EX
- FLUSH  in  1  branch/jump flush; inserts bubble into ID/EX
- RS1_DATA_ID, RS2_DATA_ID, IMM_ID, PC_ID  in  XLEN  decode-stage operands
- ARS1_ID, ARS2_ID, ARD_ID  in  REG_AW  decode-stage register addresses
- ALU_OP_ID  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10-15 give result 0
- ALU_SRC_ID  in  1  1 = operand B is IMM
- REGWRITE_ID, MEMREAD_ID, MEMWRITE_ID  in  1  decode-stage controls
- FORWARD_A, FORWARD_B  in  2  00 register file, 10 EX/MEM result, 01 MEM/WB data, 11 treated as 00
- WB_DATA  in  XLEN  MEM/WB writeback value
- ARS1, ARS2  out  REG_AW  ID/EX source addresses (to forwarding unit)
- ARD_EX, MEMREAD_EX  out  REG_AW/1  ID/EX destination and load flag (to hazard unit)
- ALU_RESULT_EX_MEM, STORE_DATA_EX_MEM  out  XLEN  EX/MEM register
- ARD_EX_MEM  out  REG_AW  EX/MEM destination
- REGWRITE_EX_MEM, MEMREAD_EX_MEM, MEMWRITE_EX_MEM  out  1  EX/MEM controls

Behaviour:
- Reset (RST_N low, asynchronous):
  - Every ID/EX and EX/MEM field, and therefore every output, is cleared to 0.
  - Reset takes effect immediately and holds while RST_N is low.
  - First capture happens on the first rising CLK after release.
- ID/EX register, on each rising edge:
  - FLUSH=1 (priority over STALL) or STALL=1: load a bubble. REGWRITE, MEMREAD and MEMWRITE are 0. ARD, ARS1 and ARS2 are 0, so a bubble never matches in forwarding. Data fields are don't-care and are cleared to 0.
  - Otherwise: load all *_ID inputs.
- EX combinational path:
  - opA = mux(FORWARD_A): RS1 (ID/EX), ALU_RESULT_EX_MEM, or WB_DATA.
  - fwdB = mux(FORWARD_B) over the same three sources.
  - opB = IMM if ALU_SRC, else fwdB.
  - Shifts use opB[4:0].
  - SLT is signed compare and SLTU is unsigned compare; both produce a 0/1 result zero-extended.
  - ADD and SUB wrap modulo 2^XLEN; there is no overflow flag.
- EX/MEM register:
  - Always advances every cycle; it is never stalled.
  - Captures: ALU result; STORE_DATA = fwdB, so stores see forwarded data even when ALU_SRC=1; ARD; the three controls.
  - If ARD=0, REGWRITE_EX_MEM is still passed as-is. Suppressing writes to x0 is the forwarding unit's and register file's job.
- Latency:
  - Instruction presented at ID in cycle n appears on the EX/MEM outputs after the edge ending cycle n+1.
  - A bubble inserted at edge n reaches EX/MEM at edge n+1 with all controls 0.
- Simultaneous events:
  - STALL and FLUSH together produce one bubble, identical to FLUSH alone.
  - FORWARD=10 uses the pre-edge ALU_RESULT_EX_MEM, i.e. the older instruction's result, never the current ALU output.
- No internal state beyond the two pipeline registers; no FSM.

Test Plan:
- Reset mid-run: drive ADD with RS1=5, RS2=7, then pull RST_N low between edges -> all outputs go to 0 immediately, before the next edge; after release, the next instruction is captured normally.
- Back-to-back dependency: ADD x1=3+4, then SUB x2 with ARS1=1, RS1_DATA=stale 99, RS2=2, FORWARD_A=10 -> second ALU_RESULT_EX_MEM=5 (7-2), ARD_EX_MEM=2.
- MEM/WB forwarding on B with store: MEMWRITE, ALU_SRC=1, IMM=8, RS1=0x100, FORWARD_B=01, WB_DATA=0xDEAD -> ALU_RESULT=0x108, STORE_DATA=0xDEAD.
- Load-use stall: STALL=1 for one cycle with a valid ADD at ID -> the next EX/MEM has REGWRITE/MEMREAD/MEMWRITE=0 and ARD=0; ARS1/ARS2 outputs read 0 during the bubble.
- STALL+FLUSH together: both asserted -> exactly one bubble; the following unflushed instruction flows through with correct result.
- ALU edge cases:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU the same pair -> 0.
  - ADD 0xFFFFFFFF+1 -> 0.
  - FORWARD_A=11 -> register-file value used.
  - ALU_OP=12 -> 0.

Source files
------------

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, forwarding muxes, ALU and EX/MEM register.
// Bubbles clear addresses and controls so they never match in forwarding.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic [XLEN-1:0]   RS1_DATA_ID,
  input  logic [XLEN-1:0]   RS2_DATA_ID,
  input  logic [XLEN-1:0]   IMM_ID,
  input  logic [XLEN-1:0]   PC_ID,
  input  logic [REG_AW-1:0] ARS1_ID,
  input  logic [REG_AW-1:0] ARS2_ID,
  input  logic [REG_AW-1:0] ARD_ID,
  input  logic [3:0]        ALU_OP_ID,
  input  logic              ALU_SRC_ID,
  input  logic              REGWRITE_ID,
  input  logic              MEMREAD_ID,
  input  logic              MEMWRITE_ID,
  input  logic [1:0]        FORWARD_A,
  input  logic [1:0]        FORWARD_B,
  input  logic [XLEN-1:0]   WB_DATA,
  output logic [REG_AW-1:0] ARS1,
  output logic [REG_AW-1:0] ARS2,
  output logic [REG_AW-1:0] ARD_EX,
  output logic              MEMREAD_EX,
  output logic [XLEN-1:0]   ALU_RESULT_EX_MEM,
  output logic [XLEN-1:0]   STORE_DATA_EX_MEM,
  output logic [REG_AW-1:0] ARD_EX_MEM,
  output logic              REGWRITE_EX_MEM,
  output logic              MEMREAD_EX_MEM,
  output logic              MEMWRITE_EX_MEM
);

  localparam int SW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] ars1;
    logic [REG_AW-1:0] ars2;
    logic [REG_AW-1:0] ard;
    logic [3:0]        op;
    logic              src;
    logic              rw;
    logic              mr;
    logic              mw;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   store;
    logic [REG_AW-1:0] ard;
    logic              rw;
    logic              mr;
    logic              mw;
  } ex_mem_t;

  id_ex_t  id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res;
  logic [SW-1:0]   shamt;
  logic            unused_pc;

  always_comb begin
    id_ex_d = '0;
    if (!(FLUSH || STALL)) begin
      id_ex_d.rs1  = RS1_DATA_ID;
      id_ex_d.rs2  = RS2_DATA_ID;
      id_ex_d.imm  = IMM_ID;
      id_ex_d.pc   = PC_ID;
      id_ex_d.ars1 = ARS1_ID;
      id_ex_d.ars2 = ARS2_ID;
      id_ex_d.ard  = ARD_ID;
      id_ex_d.op   = ALU_OP_ID;
      id_ex_d.src  = ALU_SRC_ID;
      id_ex_d.rw   = REGWRITE_ID;
      id_ex_d.mr   = MEMREAD_ID;
      id_ex_d.mw   = MEMWRITE_ID;
    end
  end

  // 10 selects the pre-edge EX/MEM result, never this cycle's ALU output.
  always_comb begin
    case (FORWARD_A)
      2'b10:   op_a = ex_mem_q.alu;
      2'b01:   op_a = WB_DATA;
      default: op_a = id_ex_q.rs1;
    endcase
    case (FORWARD_B)
      2'b10:   fwd_b = ex_mem_q.alu;
      2'b01:   fwd_b = WB_DATA;
      default: fwd_b = id_ex_q.rs2;
    endcase
    op_b  = id_ex_q.src ? id_ex_q.imm : fwd_b;
    shamt = op_b[SW-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (id_ex_q.op)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = op_a << shamt;
      4'd6: alu_res = op_a >> shamt;
      4'd7: alu_res = $signed(op_a) >>> shamt;
      4'd8: alu_res = {{(XLEN-1){1'b0}},
                       $signed(op_a) < $signed(op_b)};
      4'd9: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d       = '0;
    ex_mem_d.alu   = alu_res;
    ex_mem_d.store = fwd_b;
    ex_mem_d.ard   = id_ex_q.ard;
    ex_mem_d.rw    = id_ex_q.rw;
    ex_mem_d.mr    = id_ex_q.mr;
    ex_mem_d.mw    = id_ex_q.mw;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign unused_pc = ^id_ex_q.pc;

  assign ARS1              = id_ex_q.ars1;
  assign ARS2              = id_ex_q.ars2;
  assign ARD_EX            = id_ex_q.ard;
  assign MEMREAD_EX        = id_ex_q.mr;
  assign ALU_RESULT_EX_MEM = ex_mem_q.alu;
  assign STORE_DATA_EX_MEM = ex_mem_q.store;
  assign ARD_EX_MEM        = ex_mem_q.ard;
  assign REGWRITE_EX_MEM   = ex_mem_q.rw;
  assign MEMREAD_EX_MEM    = ex_mem_q.mr;
  assign MEMWRITE_EX_MEM   = ex_mem_q.mw;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: instruction-level model feeds an
// expectation queue that a monitor drains after every clock edge.
module tb_ex_stage;

  logic        CLK = 0;
  logic        RST_N = 0;
  logic        STALL = 0, FLUSH = 0;
  logic [31:0] RS1_DATA_ID = 0, RS2_DATA_ID = 0;
  logic [31:0] IMM_ID = 0, PC_ID = 0;
  logic [4:0]  ARS1_ID = 0, ARS2_ID = 0, ARD_ID = 0;
  logic [3:0]  ALU_OP_ID = 0;
  logic        ALU_SRC_ID = 0;
  logic        REGWRITE_ID = 0, MEMREAD_ID = 0, MEMWRITE_ID = 0;
  logic [1:0]  FORWARD_A = 0, FORWARD_B = 0;
  logic [31:0] WB_DATA = 0;
  logic [4:0]  ARS1, ARS2, ARD_EX;
  logic        MEMREAD_EX;
  logic [31:0] ALU_RESULT_EX_MEM, STORE_DATA_EX_MEM;
  logic [4:0]  ARD_EX_MEM;
  logic        REGWRITE_EX_MEM, MEMREAD_EX_MEM, MEMWRITE_EX_MEM;

  ex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH),
    .RS1_DATA_ID(RS1_DATA_ID), .RS2_DATA_ID(RS2_DATA_ID),
    .IMM_ID(IMM_ID), .PC_ID(PC_ID),
    .ARS1_ID(ARS1_ID), .ARS2_ID(ARS2_ID), .ARD_ID(ARD_ID),
    .ALU_OP_ID(ALU_OP_ID), .ALU_SRC_ID(ALU_SRC_ID),
    .REGWRITE_ID(REGWRITE_ID), .MEMREAD_ID(MEMREAD_ID),
    .MEMWRITE_ID(MEMWRITE_ID),
    .FORWARD_A(FORWARD_A), .FORWARD_B(FORWARD_B),
    .WB_DATA(WB_DATA),
    .ARS1(ARS1), .ARS2(ARS2), .ARD_EX(ARD_EX),
    .MEMREAD_EX(MEMREAD_EX),
    .ALU_RESULT_EX_MEM(ALU_RESULT_EX_MEM),
    .STORE_DATA_EX_MEM(STORE_DATA_EX_MEM),
    .ARD_EX_MEM(ARD_EX_MEM),
    .REGWRITE_EX_MEM(REGWRITE_EX_MEM),
    .MEMREAD_EX_MEM(MEMREAD_EX_MEM),
    .MEMWRITE_EX_MEM(MEMWRITE_EX_MEM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  ars1, ars2, ard;
    logic [3:0]  op;
    logic        src, rw, mr, mw;
  } instr_t;

  typedef struct {
    logic [31:0] alu, store;
    logic [4:0]  ard;
    logic        rw, mr, mw;
    logic [4:0]  ars1, ars2, ard_ex;
    logic        mr_ex;
  } exp_t;

  exp_t   q[$];
  instr_t in_ex;
  instr_t nop;
  logic [31:0] mem_alu;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    logic [31:0] ones;
    s = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    case (op)
      0: return a + b;
      1: return a + (~b) + 1;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * (32'd1 << s);
      6: return a / (32'd1 << s);
      7: return (a / (32'd1 << s)) | (a[31] ? ~(ones >> s) : 32'd0);
      8: return {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      9: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel,
                                       input logic [31:0] reg_v,
                                       input logic [31:0] wb);
    if (sel == 2'b10) return mem_alu;
    if (sel == 2'b01) return wb;
    return reg_v;
  endfunction

  task automatic clear_model();
    in_ex   = nop;
    mem_alu = 0;
    q.delete();
  endtask

  // One cycle: new instruction at ID, forwarding for the one in EX.
  task automatic issue(input instr_t i, input logic st, input logic fl,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] wb);
    exp_t e;
    logic [31:0] a, bf, b;
    @(negedge CLK);
    RS1_DATA_ID = i.rs1; RS2_DATA_ID = i.rs2;
    IMM_ID = i.imm; PC_ID = i.pc;
    ARS1_ID = i.ars1; ARS2_ID = i.ars2; ARD_ID = i.ard;
    ALU_OP_ID = i.op; ALU_SRC_ID = i.src;
    REGWRITE_ID = i.rw; MEMREAD_ID = i.mr; MEMWRITE_ID = i.mw;
    STALL = st; FLUSH = fl;
    FORWARD_A = fa; FORWARD_B = fb; WB_DATA = wb;
    a  = pick(fa, in_ex.rs1, wb);
    bf = pick(fb, in_ex.rs2, wb);
    b  = in_ex.src ? in_ex.imm : bf;
    e.alu = alu_ref(in_ex.op, a, b);
    e.store = bf;
    e.ard = in_ex.ard;
    e.rw = in_ex.rw; e.mr = in_ex.mr; e.mw = in_ex.mw;
    in_ex = (st || fl) ? nop : i;
    mem_alu = e.alu;
    e.ars1 = in_ex.ars1; e.ars2 = in_ex.ars2;
    e.ard_ex = in_ex.ard; e.mr_ex = in_ex.mr;
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: every post-edge output set is checked against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu", ALU_RESULT_EX_MEM, e.alu);
        chk("store", STORE_DATA_EX_MEM, e.store);
        chk("ard_mem", {27'd0, ARD_EX_MEM}, {27'd0, e.ard});
        chk("ctl_mem", {29'd0, REGWRITE_EX_MEM, MEMREAD_EX_MEM,
                        MEMWRITE_EX_MEM}, {29'd0, e.rw, e.mr, e.mw});
        chk("idex", {12'd0, ARS1, ARS2, ARD_EX, MEMREAD_EX},
            {12'd0, e.ars1, e.ars2, e.ard_ex, e.mr_ex});
      end
    end
  end

  function automatic instr_t mk(input logic [3:0] op,
                                input logic [31:0] r1,
                                input logic [31:0] r2,
                                input logic [4:0] rd);
    instr_t i;
    i = nop;
    i.op = op; i.rs1 = r1; i.rs2 = r2; i.ard = rd; i.rw = 1'b1;
    i.ars1 = 5'd3; i.ars2 = 5'd4;
    return i;
  endfunction

  task automatic run_one(input string name, input instr_t i,
                         input logic [1:0] fa, input logic [31:0] wb,
                         input logic [31:0] want);
    issue(i, 0, 0, 2'b00, 2'b00, 0);
    issue(nop, 0, 0, fa, 2'b00, wb);
    after_edge();
    chk(name, ALU_RESULT_EX_MEM, want);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    instr_t i;
    nop = '{default: '0};
    clear_model();
    #2;
    chk("rst_alu", ALU_RESULT_EX_MEM, 0);
    chk("rst_ctl", {REGWRITE_EX_MEM, MEMREAD_EX_MEM, MEMWRITE_EX_MEM,
                    MEMREAD_EX}, 0);
    chk("rst_addr", {ARS1, ARS2, ARD_EX, ARD_EX_MEM}, 0);
    @(negedge CLK);
    RST_N = 1;

    // ADD 5+7 in flight, then asynchronous reset between edges
    i = mk(0, 5, 7, 5'd6);
    issue(i, 0, 0, 0, 0, 0);
    issue(nop, 0, 0, 0, 0, 0);
    after_edge();
    chk("pre_rst_add", ALU_RESULT_EX_MEM, 32'd12);
    #1;
    RST_N = 0;
    #1;
    chk("mid_rst_alu", ALU_RESULT_EX_MEM, 0);
    chk("mid_rst_misc", {STORE_DATA_EX_MEM[26:0], ARD_EX_MEM,
        REGWRITE_EX_MEM, ARD_EX}, 0);
    clear_model();
    @(negedge CLK);
    RST_N = 1;
    run_one("post_rst_add", mk(0, 32'd20, 32'd22, 5'd1), 0, 0, 32'd42);

    // back-to-back dependency through EX/MEM
    issue(mk(0, 3, 4, 5'd1), 0, 0, 0, 0, 0);
    i = mk(1, 32'd99, 32'd2, 5'd2);
    i.ars1 = 5'd1;
    issue(i, 0, 0, 0, 0, 0);
    issue(nop, 0, 0, 2'b10, 2'b00, 0);
    after_edge();
    chk("fwd_exmem_sub", ALU_RESULT_EX_MEM, 32'd5);
    chk("fwd_exmem_ard", {27'd0, ARD_EX_MEM}, 32'd2);

    // store with MEM/WB forwarding on B
    i = nop;
    i.mw = 1; i.src = 1; i.imm = 8; i.rs1 = 32'h100; i.rs2 = 32'h55;
    issue(i, 0, 0, 0, 0, 0);
    issue(nop, 0, 0, 2'b00, 2'b01, 32'hDEAD);
    after_edge();
    chk("store_addr", ALU_RESULT_EX_MEM, 32'h108);
    chk("store_data", STORE_DATA_EX_MEM, 32'hDEAD);
    chk("store_mw", {31'd0, MEMWRITE_EX_MEM}, 1);

    // load-use stall bubble
    i = mk(0, 1, 2, 5'd7);
    issue(i, 1, 0, 0, 0, 0);
    after_edge();
    chk("stall_ars", {22'd0, ARS1, ARS2}, 0);
    issue(nop, 0, 0, 0, 0, 0);
    after_edge();
    chk("stall_ctl", {REGWRITE_EX_MEM, MEMREAD_EX_MEM,
                      MEMWRITE_EX_MEM}, 0);
    chk("stall_ard", {27'd0, ARD_EX_MEM}, 0);

    // stall+flush: one bubble, then a normal instruction
    issue(mk(0, 9, 9, 5'd8), 1, 1, 0, 0, 0);
    after_edge();
    chk("sf_bubble", {ARS1, ARS2, ARD_EX}, 0);
    run_one("sf_follow", mk(0, 10, 20, 5'd9), 0, 0, 32'd30);

    // ALU edge cases
    i = mk(7, 32'h8000_0000, 0, 5'd1);
    i.src = 1; i.imm = 31;
    run_one("sra31", i, 0, 0, 32'hFFFF_FFFF);
    run_one("slt", mk(8, 32'hFFFF_FFFF, 1, 5'd1), 0, 0, 1);
    run_one("sltu", mk(9, 32'hFFFF_FFFF, 1, 5'd1), 0, 0, 0);
    run_one("add_wrap", mk(0, 32'hFFFF_FFFF, 1, 5'd1), 0, 0, 0);
    run_one("fwd11", mk(0, 32'h11, 32'h22, 5'd1), 2'b11,
            32'hBAD0, 32'h33);
    run_one("op12", mk(12, 32'h1234, 32'h5678, 5'd1), 0, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      i.rs1 = rnd_val(); i.rs2 = rnd_val();
      i.imm = rnd_val(); i.pc = $urandom;
      i.ars1 = 5'($urandom); i.ars2 = 5'($urandom);
      i.ard = 5'($urandom);
      i.op = 4'($urandom);
      i.src = 1'($urandom); i.rw = 1'($urandom);
      i.mr = 1'($urandom); i.mw = 1'($urandom);
      issue(i, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            2'($urandom), 2'($urandom), rnd_val());
    end
    after_edge();
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
